pixel_stream_checker: RTL and testbench
=======================================

// Module: pixel_stream_checker
// PURPOSE
//  Synthesizable, parametrised self-checker for RGB pixel streams: buffers the DUT's
//  actual pixel stream, pairs each pixel with an expected pixel from a golden-source
//  stream, counts per-channel mismatches over one frame of IMG_W x IMG_H pixels.
//  Sits beside the VGA/colourspace output path for on-board or sim-time golden checks.
// PARAMETERS
//  CH_WIDTH       8    bits per colour channel
//  NUM_CH         3    channels per pixel (R,G,B = ch2,ch1,ch0; ch0 in LSBs)
//  IMG_W          320  pixels per row
//  IMG_H          240  rows per frame
//  FIFO_DEPTH     8    actual-pixel buffer depth (power of 2, >=2)
//  MAX_MISMATCHES 10   Halt once Mismatch_count exceeds this value
//  CNT_WIDTH      16   width of Mismatch_count (saturating)
// PORTS
//  Clock            in   1                 system clock
//  Reset            in   1                 async, active-high
//  Start            in   1                 1-cycle pulse: clear and arm a new frame
//  Act_valid        in   1                 actual pixel present (no backpressure)
//  Act_data         in   NUM_CH*CH_WIDTH   actual pixel
//  Exp_valid        in   1                 expected pixel present
//  Exp_data         in   NUM_CH*CH_WIDTH   expected pixel
//  Exp_ready        out  1                 expected pixel consumed this cycle
//  Busy             out  1                 state == CHECK
//  Done             out  1                 full frame compared, not halted (level)
//  Halt             out  1                 mismatch limit exceeded (level)
//  Overflow         out  1                 sticky: actual pixel dropped, FIFO full
//  Mismatch_count   out  CNT_WIDTH         total channel mismatches this frame
//  Ch_err_mask      out  NUM_CH            sticky per-channel mismatch flags
//  First_err_valid  out  1                 first-error coordinates captured
//  First_err_col    out  $clog2(IMG_W)     column of first mismatching pixel
//  First_err_row    out  $clog2(IMG_H)     row of first mismatching pixel
// BEHAVIOUR
//  Reset: state IDLE; FIFO empty; all outputs and counters 0.
//  States: IDLE -Start-> CHECK; CHECK -last pixel compared-> DONE;
//   CHECK -count>MAX_MISMATCHES-> HALT; Start in any state -> CHECK (restart).
//  Start: flushes FIFO; clears count, mask, Overflow, First_err_*, row/col; Done/Halt 0
//   next cycle. Act_valid on the Start cycle is discarded.
//  Act_valid written to FIFO only in CHECK; ignored in IDLE/DONE/HALT.
//  Act_valid with FIFO full: pixel dropped, Overflow=1 (sticky), row/col not advanced.
//  Pop: Exp_ready = Busy & FIFO non-empty (combinational); pair consumed when
//   Exp_ready & Exp_valid. Simultaneous push and pop on a full FIFO is legal, no drop.
//  Compare registered: 1 cycle after pop, Mismatch_count += number of differing
//   channels (0..NUM_CH), saturates at 2^CNT_WIDTH-1; Ch_err_mask |= diff vector.
//  First mismatch of the frame latches row/col of that pixel, First_err_valid=1;
//   later mismatches do not overwrite.
//  Position: col increments per popped pixel, wraps IMG_W-1 -> 0 with row++.
//   Pixel (IMG_W-1, IMG_H-1) popped -> DONE on the compare cycle; remaining FIFO
//   entries discarded.
//  Halt check uses the updated count; if last pixel also exceeds limit, HALT wins.
//  In HALT/DONE no further pops; outputs hold until Start or Reset.
//  Reset mid-frame: immediate return to reset state, no partial results retained.
// TESTING
//  1 Start, 320x240 identical act/exp streams -> Done=1, count=0, mask=0, Halt=0.
//  2 Pixel (5,2) exp R=0x10, act R=0x11 -> count=1, mask=3'b100, First_err=(5,2).
//  3 Pixels with all 3 ch wrong from index 0 -> count 3,6,9,12; Halt after 4th pixel.
//  4 Exp_valid low 12 cycles, 9 Act pixels -> Overflow=1, 8 compared, col=8 after.
//  5 Start asserted mid-frame at pixel 100 -> count 0, row/col 0, FIFO empty, Busy=1.
//  6 Reset asserted in HALT -> all outputs 0 same cycle (async), state IDLE.

Source files
------------

// File: rtl/pixel_stream_checker.sv
// Golden-reference checker for RGB pixel streams: buffers actual pixels, pairs each with
// an expected pixel and tallies per-channel mismatches across one IMG_W x IMG_H frame.
module pixel_stream_checker #(
  parameter int CH_WIDTH       = 8,
  parameter int NUM_CH         = 3,
  parameter int IMG_W          = 320,
  parameter int IMG_H          = 240,
  parameter int FIFO_DEPTH     = 8,
  parameter int MAX_MISMATCHES = 10,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                       clock_50,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       act_valid,
  input  logic [NUM_CH*CH_WIDTH-1:0] act_data,
  input  logic                       exp_valid,
  input  logic [NUM_CH*CH_WIDTH-1:0] exp_data,
  output logic                       exp_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       halt,
  output logic                       overflow,
  output logic [CNT_WIDTH-1:0]       mismatch_count,
  output logic [NUM_CH-1:0]          ch_err_mask,
  output logic                       first_err_valid,
  output logic [$clog2(IMG_W)-1:0]   first_err_col,
  output logic [$clog2(IMG_H)-1:0]   first_err_row
);
  localparam int PIX_W = NUM_CH * CH_WIDTH;
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [COL_W-1:0]     LAST_COL = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]     LAST_ROW = ROW_W'(IMG_H - 1);
  localparam logic [PTR_W:0]       FULL_LVL = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH:0]   HALT_LIM = (CNT_WIDTH + 1)'(MAX_MISMATCHES);

  typedef enum logic [1:0] {IDLE, CHECK, DONE, HALT} state_t;
  state_t state_reg;

  logic [PIX_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]   fill_reg;
  logic [COL_W-1:0] col_reg, cmp_col_reg;
  logic [ROW_W-1:0] row_reg, cmp_row_reg;
  logic [PIX_W-1:0] cmp_act_reg, cmp_exp_reg;
  logic             cmp_valid_reg, cmp_last_reg;

  logic fifo_full, fifo_empty, push, pop;
  logic [NUM_CH-1:0]    diff;
  logic [CNT_WIDTH:0]   sum_raw;
  logic [CNT_WIDTH-1:0] count_next;

  assign busy       = (state_reg == CHECK);
  assign done       = (state_reg == DONE);
  assign halt       = (state_reg == HALT);
  assign fifo_full  = (fill_reg == FULL_LVL);
  assign fifo_empty = (fill_reg == '0);
  assign exp_ready  = busy & ~fifo_empty;
  assign pop        = exp_ready & exp_valid & ~start;
  // A full FIFO still accepts a pixel when the head leaves in the same cycle.
  assign push       = busy & act_valid & ~start & (~fifo_full | pop);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_diff
      assign diff[gi] = (cmp_act_reg[gi*CH_WIDTH +: CH_WIDTH] != cmp_exp_reg[gi*CH_WIDTH +: CH_WIDTH]);
    end
  endgenerate

  always_comb begin
    sum_raw = {1'b0, mismatch_count};
    for (int i = 0; i < NUM_CH; i++) begin
      sum_raw = sum_raw + (CNT_WIDTH + 1)'(diff[i]);
    end
    count_next = sum_raw[CNT_WIDTH] ? '1 : sum_raw[CNT_WIDTH-1:0];
  end

  always_ff @(posedge clock_50) begin
    if (push) fifo_mem[wr_ptr_reg] <= act_data;
  end

  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      fill_reg        <= '0;
      col_reg         <= '0;
      row_reg         <= '0;
      cmp_valid_reg   <= 1'b0;
      cmp_last_reg    <= 1'b0;
      cmp_act_reg     <= '0;
      cmp_exp_reg     <= '0;
      cmp_col_reg     <= '0;
      cmp_row_reg     <= '0;
      overflow        <= 1'b0;
      mismatch_count  <= '0;
      ch_err_mask     <= '0;
      first_err_valid <= 1'b0;
      first_err_col   <= '0;
      first_err_row   <= '0;
    end else if (start) begin
      state_reg       <= CHECK;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      fill_reg        <= '0;
      col_reg         <= '0;
      row_reg         <= '0;
      cmp_valid_reg   <= 1'b0;
      cmp_last_reg    <= 1'b0;
      overflow        <= 1'b0;
      mismatch_count  <= '0;
      ch_err_mask     <= '0;
      first_err_valid <= 1'b0;
      first_err_col   <= '0;
      first_err_row   <= '0;
    end else begin
      if (push && !pop)      fill_reg <= fill_reg + (PTR_W + 1)'(1);
      else if (pop && !push) fill_reg <= fill_reg - (PTR_W + 1)'(1);
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (busy && act_valid && fifo_full && !pop) overflow <= 1'b1;

      cmp_valid_reg <= pop;
      if (pop) begin
        rd_ptr_reg   <= rd_ptr_reg + PTR_W'(1);
        cmp_act_reg  <= fifo_mem[rd_ptr_reg];
        cmp_exp_reg  <= exp_data;
        cmp_col_reg  <= col_reg;
        cmp_row_reg  <= row_reg;
        cmp_last_reg <= (col_reg == LAST_COL) && (row_reg == LAST_ROW);
        if (col_reg == LAST_COL) begin
          col_reg <= '0;
          row_reg <= (row_reg == LAST_ROW) ? '0 : row_reg + ROW_W'(1);
        end else begin
          col_reg <= col_reg + COL_W'(1);
        end
      end

      // Results of a pair popped on the final CHECK cycle are dropped once DONE/HALT.
      if (cmp_valid_reg && busy) begin
        mismatch_count <= count_next;
        ch_err_mask    <= ch_err_mask | diff;
        if ((|diff) && !first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_col   <= cmp_col_reg;
          first_err_row   <= cmp_row_reg;
        end
        if ({1'b0, count_next} > HALT_LIM) state_reg <= HALT;
        else if (cmp_last_reg)             state_reg <= DONE;
      end
    end
  end
endmodule

// File: tb/tb_pixel_stream_checker.sv
// Directed-sequence bench with random pixel data, checked every cycle against a
// queue-based frame model plus constant expectations at the key points of each scenario.
module tb_pixel_stream_checker;
  localparam int W = 320;
  localparam int H = 240;
  localparam int DEPTH = 8;
  localparam int MAXM = 10;
  localparam int CNT_MAX = 65535;

  logic        clock_50 = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        act_valid = 1'b0;
  logic [23:0] act_data = '0;
  logic        exp_valid = 1'b0;
  logic [23:0] exp_data = '0;
  logic        exp_ready, busy, done, halt, overflow, first_err_valid;
  logic [15:0] mismatch_count;
  logic [2:0]  ch_err_mask;
  logic [8:0]  first_err_col;
  logic [7:0]  first_err_row;

  pixel_stream_checker dut (
    .clock_50(clock_50), .reset(reset), .start(start),
    .act_valid(act_valid), .act_data(act_data),
    .exp_valid(exp_valid), .exp_data(exp_data), .exp_ready(exp_ready),
    .busy(busy), .done(done), .halt(halt), .overflow(overflow),
    .mismatch_count(mismatch_count), .ch_err_mask(ch_err_mask),
    .first_err_valid(first_err_valid), .first_err_col(first_err_col),
    .first_err_row(first_err_row)
  );

  always #5 clock_50 = ~clock_50;

  int checks = 0;
  int errors = 0;

  // Frame model: FIFO contents as a queue, pixel index -> (col,row) by division.
  bit          m_busy, m_done, m_halt, m_ovf, m_fv, m_pend;
  logic [23:0] m_q[$];
  int          m_count, m_idx, m_pidx, m_fc, m_fr, m_pend_idx;
  logic [2:0]  m_mask;
  logic [23:0] m_pend_act, m_pend_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_clear(input bit armed);
    m_busy = armed; m_done = 0; m_halt = 0; m_ovf = 0; m_fv = 0; m_pend = 0;
    m_q.delete();
    m_count = 0; m_idx = 0; m_pidx = 0; m_fc = 0; m_fr = 0; m_mask = '0;
  endtask

  task automatic model_update(input bit st, input bit av, input logic [23:0] ad,
                              input bit ev, input logic [23:0] ed);
    bit ob, pop;
    int nd;
    logic [2:0] dv;
    if (st) begin
      model_clear(1'b1);
      return;
    end
    ob  = m_busy;
    pop = ob && (m_q.size() > 0) && ev;
    if (m_pend && ob) begin
      nd = 0;
      for (int c = 0; c < 3; c++) begin
        dv[c] = (m_pend_act[8*c +: 8] != m_pend_exp[8*c +: 8]);
        nd += int'(dv[c]);
      end
      m_count = (m_count + nd > CNT_MAX) ? CNT_MAX : m_count + nd;
      m_mask |= dv;
      if (nd > 0 && !m_fv) begin
        m_fv = 1; m_fc = m_pend_idx % W; m_fr = m_pend_idx / W;
      end
      if (m_count > MAXM) begin m_busy = 0; m_halt = 1; end
      else if (m_pend_idx == W*H - 1) begin m_busy = 0; m_done = 1; end
    end
    m_pend = 0;
    if (pop) begin
      m_pend_act = m_q.pop_front();
      m_pend_exp = ed;
      m_pend_idx = m_idx;
      m_pend = 1;
      m_idx++;
    end
    if (ob && av) begin
      if (m_q.size() < DEPTH) begin m_q.push_back(ad); m_pidx++; end
      else m_ovf = 1;
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, "/exp_ready"}, 32'(exp_ready), 32'(m_busy && (m_q.size() > 0)));
    chk({ph, "/busy"}, 32'(busy), 32'(m_busy));
    chk({ph, "/done"}, 32'(done), 32'(m_done));
    chk({ph, "/halt"}, 32'(halt), 32'(m_halt));
    chk({ph, "/overflow"}, 32'(overflow), 32'(m_ovf));
    chk({ph, "/count"}, 32'(mismatch_count), 32'(m_count));
    chk({ph, "/mask"}, 32'(ch_err_mask), 32'(m_mask));
    chk({ph, "/ferr_v"}, 32'(first_err_valid), 32'(m_fv));
    chk({ph, "/ferr_col"}, 32'(first_err_col), 32'(m_fc));
    chk({ph, "/ferr_row"}, 32'(first_err_row), 32'(m_fr));
  endtask

  // One clock: drive at negedge, advance model, check at the following negedge.
  // The expected pixel mirrors the model's FIFO head, xor'd with a deliberate corruption.
  task automatic step(input string ph, input bit st, input bit av, input logic [23:0] ad,
                      input bit ev, input logic [23:0] exor);
    logic [23:0] head;
    head      = (m_q.size() > 0) ? m_q[0] : 24'($urandom);
    start     = st;
    act_valid = av;
    act_data  = ad;
    exp_valid = ev;
    exp_data  = head ^ exor;
    model_update(st, av, ad, ev, exp_data);
    @(posedge clock_50);
    @(negedge clock_50);
    check_all(ph);
  endtask

  function automatic logic [23:0] rpix();
    return 24'($urandom);
  endfunction

  initial begin
    logic [23:0] p;
    model_clear(1'b0);
    repeat (2) @(negedge clock_50);
    check_all("reset");
    reset = 1'b0;
    @(negedge clock_50);
    check_all("idle");

    // 1: full frame, identical streams
    step("t1", 1, 0, '0, 0, '0);
    for (int i = 0; i < W*H + 20 && !m_done; i++) step("t1", 0, 1, rpix(), 1, '0);
    repeat (4) step("t1_hold", 0, 1, rpix(), 1, '0);
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_count", 32'(mismatch_count), 32'd0);
    chk("t1_mask", 32'(ch_err_mask), 32'd0);
    chk("t1_halt", 32'(halt), 32'd0);

    // 2: single red mismatch at pixel (5,2)
    step("t2", 1, 0, '0, 0, '0);
    for (int i = 0; i < 2000 && m_idx < 2*W + 5 + 3; i++) begin
      p = rpix();
      if (m_pidx == 2*W + 5) p[23:16] = 8'h11;
      step("t2", 0, 1, p, 1, (m_idx == 2*W + 5) ? 24'h010000 : 24'h0);
    end
    chk("t2_count", 32'(mismatch_count), 32'd1);
    chk("t2_mask", 32'(ch_err_mask), 32'b100);
    chk("t2_ferr_col", 32'(first_err_col), 32'd5);
    chk("t2_ferr_row", 32'(first_err_row), 32'd2);

    // 3: every channel wrong from pixel 0 -> halt after the fourth pixel
    step("t3", 1, 0, '0, 0, '0);
    for (int i = 0; i < 8; i++) step("t3", 0, 1, rpix(), 1, 24'h010101);
    chk("t3_count", 32'(mismatch_count), 32'd12);
    chk("t3_halt", 32'(halt), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_mask", 32'(ch_err_mask), 32'b111);

    // 4: expected stream stalled while 9 actual pixels arrive
    step("t4", 1, 0, '0, 0, '0);
    for (int i = 0; i < 9; i++) step("t4", 0, 1, rpix(), 0, '0);
    repeat (2) step("t4", 0, 0, '0, 0, '0);
    repeat (10) step("t4", 0, 0, '0, 1, '0);
    chk("t4_ovf", 32'(overflow), 32'd1);
    chk("t4_count0", 32'(mismatch_count), 32'd0);
    step("t4", 0, 1, rpix(), 1, '0);
    repeat (3) step("t4", 0, 0, '0, 1, (m_idx == 8) ? 24'h000001 : 24'h0);
    chk("t4_ferr_col", 32'(first_err_col), 32'd8);
    chk("t4_ferr_row", 32'(first_err_row), 32'd0);
    chk("t4_count1", 32'(mismatch_count), 32'd1);

    // 5: random traffic, then restart mid-frame at pixel 100
    step("t5", 1, 0, '0, 0, '0);
    for (int i = 0; i < 3000 && m_idx < 100 && m_busy; i++)
      step("t5", 0, $urandom_range(0, 3) != 0, rpix(), $urandom_range(0, 3) != 0,
           ($urandom_range(0, 63) == 0) ? (24'h1 << (8 * $urandom_range(0, 2))) : 24'h0);
    step("t5_restart", 1, 1, rpix(), 1, '0);
    chk("t5_count", 32'(mismatch_count), 32'd0);
    chk("t5_busy", 32'(busy), 32'd1);
    chk("t5_ready", 32'(exp_ready), 32'd0);
    chk("t5_ferr_v", 32'(first_err_valid), 32'd0);
    step("t5", 0, 1, rpix(), 1, '0);
    repeat (3) step("t5", 0, 0, '0, 1, (m_idx == 0) ? 24'h000100 : 24'h0);
    chk("t5_ferr_col", 32'(first_err_col), 32'd0);
    chk("t5_ferr_row", 32'(first_err_row), 32'd0);
    chk("t5_mask", 32'(ch_err_mask), 32'b010);

    // 6: asynchronous reset while halted
    step("t6", 1, 0, '0, 0, '0);
    for (int i = 0; i < 6; i++) step("t6", 0, 1, rpix(), 1, 24'h010101);
    chk("t6_halt", 32'(halt), 32'd1);
    start = 0; act_valid = 0; exp_valid = 0;
    #2 reset = 1'b1;
    model_clear(1'b0);
    #1 check_all("t6_async");
    chk("t6_count", 32'(mismatch_count), 32'd0);
    @(negedge clock_50);
    reset = 1'b0;
    repeat (3) step("t6_idle", 0, 1, rpix(), 1, '0);
    chk("t6_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
